// File: rtl/eq_band_mac_scheduler_pkg.sv
// eq_pkg: shared state encoding and width helpers for the band MAC scheduler
package eq_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, EMIT = 2'd2} state_t;
    function automatic int clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
    function automatic int acc_w(input int word_in, input int coef_w, input int order);
        return word_in + coef_w + clog2(order);
    endfunction
endpackage

// File: rtl/eq_band_mac_scheduler_if.sv
// eq_band_mac_scheduler_if: sample, result and coefficient-config handshakes
interface eq_band_mac_scheduler_if
    import eq_pkg::*;
#(
    parameter int ORDER     = 32,
    parameter int WORD_IN   = 8,
    parameter int WORD_OUT  = 16,
    parameter int COEF_W    = 10,
    parameter int NUM_BANDS = 3
) ();
    logic                              in_valid;
    logic                              in_ready;
    logic signed [WORD_IN-1:0]         in_data;
    logic                              out_valid;
    logic [clog2(NUM_BANDS)-1:0]       out_band;
    logic signed [WORD_OUT-1:0]        out_data;
    logic                              cfg_we;
    logic                              cfg_ready;
    logic [clog2(NUM_BANDS)-1:0]       cfg_band;
    logic [clog2(ORDER)-1:0]           cfg_tap;
    logic signed [COEF_W-1:0]          cfg_coef;
    logic                              busy;
    modport slave (
        input  in_valid, in_data, cfg_we, cfg_band, cfg_tap, cfg_coef,
        output in_ready, out_valid, out_band, out_data, cfg_ready, busy
    );
    modport master (
        output in_valid, in_data, cfg_we, cfg_band, cfg_tap, cfg_coef,
        input  in_ready, out_valid, out_band, out_data, cfg_ready, busy
    );
endinterface

// File: rtl/eq_band_mac_scheduler_coef_bank.sv
// eq_coef_bank: per-band tap coefficient register file, sync write, comb read
module eq_coef_bank
    import eq_pkg::*;
#(
    parameter int ORDER     = 32,
    parameter int COEF_W    = 10,
    parameter int NUM_BANDS = 3,
    localparam int BW = clog2(NUM_BANDS),
    localparam int TW = clog2(ORDER)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [BW-1:0]            wr_band,
    input  logic [TW-1:0]            wr_tap,
    input  logic signed [COEF_W-1:0] wr_coef,
    input  logic [BW-1:0]            rd_band,
    input  logic [TW-1:0]            rd_tap,
    output logic signed [COEF_W-1:0] rd_coef
);
    logic signed [COEF_W-1:0] mem [NUM_BANDS][ORDER];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANDS; b++)
                for (int t = 0; t < ORDER; t++)
                    mem[b][t] <= '0;
        end else if (we && int'(wr_band) < NUM_BANDS) begin
            mem[wr_band][wr_tap] <= wr_coef;
        end
    end
    assign rd_coef = mem[rd_band][rd_tap];
endmodule

// File: rtl/eq_band_mac_scheduler.sv
// eq_band_mac_scheduler: one shared MAC running every band's FIR per input sample
module eq_band_mac_scheduler
    import eq_pkg::*;
#(
    parameter int ORDER     = 32,
    parameter int WORD_IN   = 8,
    parameter int WORD_OUT  = 16,
    parameter int COEF_W    = 10,
    parameter int NUM_BANDS = 3,
    parameter int PRE_SHIFT = 3
) (
    input logic                  clk,
    input logic                  rst,
    eq_band_mac_scheduler_if.slave bus
);
    localparam int BW    = clog2(NUM_BANDS);
    localparam int TW    = clog2(ORDER);
    localparam int P_W   = WORD_IN + COEF_W;
    localparam int ACC_W = acc_w(WORD_IN, COEF_W, ORDER);

    state_t                   state;
    logic signed [WORD_IN-1:0] smp [ORDER];
    logic [TW-1:0]            wr_ptr, newest, tap, rd_idx;
    logic [BW-1:0]            band;
    logic signed [ACC_W-1:0]  acc;
    logic signed [COEF_W-1:0] coef;
    logic signed [WORD_IN-1:0] s_sh;
    logic signed [P_W-1:0]    s_ext, c_ext, prod;
    logic                     idle;

    assign idle          = (state == IDLE);
    assign bus.in_ready  = idle;
    assign bus.cfg_ready = idle;
    assign bus.busy      = !idle;

    eq_coef_bank #(.ORDER(ORDER), .COEF_W(COEF_W), .NUM_BANDS(NUM_BANDS)) u_coef (
        .clk     (clk),
        .rst     (rst),
        .we      (bus.cfg_we && idle),
        .wr_band (bus.cfg_band),
        .wr_tap  (bus.cfg_tap),
        .wr_coef (bus.cfg_coef),
        .rd_band (band),
        .rd_tap  (tap),
        .rd_coef (coef)
    );

    // tap 0 is the newest sample; ring index wraps because ORDER is a power of two
    assign rd_idx = newest - tap;
    assign s_sh   = smp[rd_idx] >>> PRE_SHIFT;
    assign s_ext  = P_W'(s_sh);
    assign c_ext  = P_W'(coef);
    assign prod   = s_ext * c_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            for (int i = 0; i < ORDER; i++) smp[i] <= '0;
            wr_ptr        <= '0;
            newest        <= '0;
            tap           <= '0;
            band          <= '0;
            acc           <= '0;
            bus.out_valid <= 1'b0;
            bus.out_band  <= '0;
            bus.out_data  <= '0;
        end else begin
            bus.out_valid <= 1'b0;
            if (state == IDLE) begin
                if (bus.in_valid) begin
                    smp[wr_ptr] <= bus.in_data;
                    newest      <= wr_ptr;
                    wr_ptr      <= wr_ptr + TW'(1);
                    band        <= '0;
                    tap         <= '0;
                    acc         <= '0;
                    state       <= MAC;
                end
            end else if (state == MAC) begin
                acc <= acc + ACC_W'(prod);
                tap <= tap + TW'(1);
                if (tap == TW'(ORDER - 1)) state <= EMIT;
            end else begin
                bus.out_valid <= 1'b1;
                bus.out_band  <= band;
                bus.out_data  <= acc[WORD_OUT-1:0];
                if (int'(band) < NUM_BANDS - 1) begin
                    band  <= band + BW'(1);
                    tap   <= '0;
                    acc   <= '0;
                    state <= MAC;
                end else begin
                    state <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_eq_band_mac_scheduler.sv
// tb_eq_band_mac_scheduler: frame-level FIR model checked against the DUT every cycle
module tb_eq_band_mac_scheduler;
    localparam int ORDER = 32, NB = 3, LAT = ORDER + 1, FRAME = 1 + NB * LAT;

    typedef struct {int c; int b; int d;} exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0, n_err = 0;

    int   mcoef [NB][ORDER];
    int   hist [ORDER];
    exp_t expq [$];
    int   next_free = 0;
    int   hold_b = 0, hold_d = 0;
    int   last_dut [NB];
    int   ov_cnt = 0;
    int   acc_q [$];
    int   ov_q [$];
    int   ovb_q [$];

    eq_band_mac_scheduler_if bus ();

    eq_band_mac_scheduler dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int wrap16(input int v);
        logic signed [15:0] w;
        w = v[15:0];
        return int'(w);
    endfunction

    // Model: at each falling edge compare the present outputs, then apply what the next rising edge does
    always @(negedge clk) begin
        if (rst) begin
            for (int b = 0; b < NB; b++) for (int t = 0; t < ORDER; t++) mcoef[b][t] = 0;
            for (int t = 0; t < ORDER; t++) hist[t] = 0;
            expq.delete();
            next_free = cyc + 1;
            hold_b = 0;
            hold_d = 0;
        end else begin
            automatic bit idle  = (cyc >= next_free);
            automatic bit exp_v = (expq.size() > 0) && (expq[0].c == cyc);
            chk("out_valid", int'(bus.out_valid), int'(exp_v));
            if (exp_v) begin
                hold_b = expq[0].b;
                hold_d = expq[0].d;
                void'(expq.pop_front());
            end
            chk("out_band", int'(bus.out_band), hold_b);
            chk("out_data", int'($signed(bus.out_data)), hold_d);
            chk("in_ready", int'(bus.in_ready), int'(idle));
            chk("cfg_ready", int'(bus.cfg_ready), int'(idle));
            chk("busy", int'(bus.busy), int'(!idle));
            if (bus.out_valid) begin
                ov_cnt++;
                last_dut[bus.out_band] = int'($signed(bus.out_data));
                ov_q.push_back(cyc);
                ovb_q.push_back(int'(bus.out_band));
            end
            if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc + 1);
            if (idle && bus.cfg_we && int'(bus.cfg_band) < NB)
                mcoef[bus.cfg_band][bus.cfg_tap] = int'($signed(bus.cfg_coef));
            if (idle && bus.in_valid) begin
                for (int t = ORDER - 1; t > 0; t--) hist[t] = hist[t-1];
                hist[0] = int'($signed(bus.in_data));
                for (int b = 0; b < NB; b++) begin
                    automatic int s = 0;
                    for (int t = 0; t < ORDER; t++) s += mcoef[b][t] * (hist[t] >>> 3);
                    expq.push_back('{c: cyc + 1 + LAT * (b + 1), b: b, d: wrap16(s)});
                end
                next_free = cyc + FRAME;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!bus.in_ready && k < 400) begin
            tick(1);
            k++;
        end
        if (!bus.in_ready) chk("wait_idle timeout", 0, 1);
    endtask

    task automatic cfg(input int b, input int t, input int c);
        wait_idle();
        bus.cfg_we   = 1'b1;
        bus.cfg_band = 2'(b);
        bus.cfg_tap  = 5'(t);
        bus.cfg_coef = 10'(c);
        tick(1);
        bus.cfg_we = 1'b0;
    endtask

    task automatic send(input int x);
        wait_idle();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'(x);
        tick(1);
        bus.in_valid = 1'b0;
    endtask

    task automatic frame(input int x);
        send(x);
        wait_idle();
        tick(1);
    endtask

    initial begin
        int ov0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.cfg_we   = 1'b0;
        bus.cfg_band = '0;
        bus.cfg_tap  = '0;
        bus.cfg_coef = '0;
        for (int b = 0; b < NB; b++) last_dut[b] = 0;
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("reset out_valid", int'(bus.out_valid), 0);
        chk("reset in_ready", int'(bus.in_ready), 1);
        chk("reset cfg_ready", int'(bus.cfg_ready), 1);
        chk("reset busy", int'(bus.busy), 0);
        chk("reset out_data", int'($signed(bus.out_data)), 0);

        for (int k = 0; k < ORDER; k++) cfg(0, k, k + 1);
        frame(64);
        chk("impulse b0 #1", last_dut[0], 8);
        chk("impulse b1", last_dut[1], 0);
        chk("impulse b2", last_dut[2], 0);
        frame(0);
        chk("impulse b0 #2", last_dut[0], 16);
        frame(0);
        chk("impulse b0 #3", last_dut[0], 24);

        cfg(1, 0, 511);
        frame(-128);
        chk("sign b1 neg", last_dut[1], -8176);
        frame(7);
        chk("sign b1 small", last_dut[1], 0);

        for (int k = 0; k < ORDER; k++) cfg(2, k, 511);
        for (int k = 0; k < ORDER; k++) frame(127);
        chk("wrap b2", last_dut[2], -16864);

        wait_idle();
        acc_q.delete();
        ov_q.delete();
        ovb_q.delete();
        bus.in_data  = 8'd40;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 250; i++) begin
            if (i == 30) begin
                bus.cfg_we   = 1'b1;
                bus.cfg_band = 2'd0;
                bus.cfg_tap  = 5'd0;
                bus.cfg_coef = 10'd99;
            end
            if (i == 34) bus.cfg_we = 1'b0;
            tick(1);
        end
        bus.in_valid = 1'b0;
        wait_idle();
        tick(1);
        chk("accept count", acc_q.size(), 3);
        chk("out pulse count", ov_q.size(), 9);
        if (acc_q.size() >= 3) begin
            chk("accept period 1", acc_q[1] - acc_q[0], FRAME);
            chk("accept period 2", acc_q[2] - acc_q[1], FRAME);
        end
        if (ov_q.size() >= 3 && acc_q.size() >= 1) begin
            chk("b0 latency", ov_q[0] - acc_q[0], 33);
            chk("b1 latency", ov_q[1] - acc_q[0], 66);
            chk("b2 latency", ov_q[2] - acc_q[0], 99);
            chk("b0 index", ovb_q[0], 0);
            chk("b1 index", ovb_q[1], 1);
            chk("b2 index", ovb_q[2], 2);
        end

        wait_idle();
        ov0 = ov_cnt;
        send(50);
        tick(10);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("abort busy", int'(bus.busy), 0);
        tick(120);
        chk("abort no out_valid", ov_cnt - ov0, 0);
        cfg(0, 0, 1);
        frame(64);
        chk("post-reset b0", last_dut[0], 8);
        chk("post-reset b1", last_dut[1], 0);
        chk("post-reset b2", last_dut[2], 0);

        tick(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
